rs_alu: RTL and testbench

Reservation station for the integer ALU in the out-of-order core. It buffers up to `RS_SIZE` dispatched ALU instructions and captures operand values from two result broadcast buses (ALU and load buffer). Each cycle it selects at most one entry whose operands are both available and drives it to the ALU's registered input interface (operands, opcode, ROB id, valid). It sits between the dispatcher and the ALU, and is cleared by a pipeline flush.

---
 rtl/rs_alu_if.sv | 48 ++++
 rtl/rs_alu.sv | 192 +++++++++++++++++++
 tb/tb_rs_alu.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_alu_if.sv
// Dispatch, result-broadcast and ALU-issue signals of the ALU reservation station.
// The master side is the dispatcher/CDB environment; the slave side is the station.
interface rs_alu_if #(
  parameter int ROB_SIZE_WIDTH       = 4,
  parameter int CALC_OP_L1_NUM_WIDTH = 4
);
  logic                            disp_valid;
  logic [CALC_OP_L1_NUM_WIDTH-1:0] disp_op_L1;
  logic                            disp_op_L2;
  logic [ROB_SIZE_WIDTH-1:0]       disp_rob_id;
  logic [31:0]                     disp_vj;
  logic [31:0]                     disp_vk;
  logic                            disp_qj_valid;
  logic                            disp_qk_valid;
  logic [ROB_SIZE_WIDTH-1:0]       disp_qj;
  logic [ROB_SIZE_WIDTH-1:0]       disp_qk;

  logic                            cdb_alu_ready;
  logic [ROB_SIZE_WIDTH-1:0]       cdb_alu_rob_id;
  logic [31:0]                     cdb_alu_value;
  logic                            cdb_lsb_ready;
  logic [ROB_SIZE_WIDTH-1:0]       cdb_lsb_rob_id;
  logic [31:0]                     cdb_lsb_value;

  logic                            alu_valid;
  logic [31:0]                     alu_opr1;
  logic [31:0]                     alu_opr2;
  logic [ROB_SIZE_WIDTH-1:0]       alu_rob_id;
  logic [CALC_OP_L1_NUM_WIDTH-1:0] alu_op_L1;
  logic                            alu_op_L2;
  logic                            full;

  modport master (
    output disp_valid, disp_op_L1, disp_op_L2, disp_rob_id, disp_vj, disp_vk,
           disp_qj_valid, disp_qk_valid, disp_qj, disp_qk,
           cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_value,
    input  alu_valid, alu_opr1, alu_opr2, alu_rob_id, alu_op_L1, alu_op_L2, full
  );

  modport slave (
    input  disp_valid, disp_op_L1, disp_op_L2, disp_rob_id, disp_vj, disp_vk,
           disp_qj_valid, disp_qk_valid, disp_qj, disp_qk,
           cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
           cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_value,
    output alu_valid, alu_opr1, alu_opr2, alu_rob_id, alu_op_L1, alu_op_L2, full
  );
endinterface

// File: rtl/rs_alu.sv
// ALU reservation station: buffers dispatched instructions, snoops both result
// buses for missing operands and issues the lowest-index ready entry each cycle.
module rs_alu #(
  parameter int RS_SIZE              = 8,
  parameter int ROB_SIZE_WIDTH       = 4,
  parameter int CALC_OP_L1_NUM_WIDTH = 4
) (
  input logic     clk_in,
  input logic     rst_in,
  input logic     rdy_in,
  input logic     need_flush_in,
  rs_alu_if.slave bus
);
  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = IW + 1;
  localparam int RW = ROB_SIZE_WIDTH;
  localparam int OW = CALC_OP_L1_NUM_WIDTH;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qjValid_q, qjValid_d;
  logic [RS_SIZE-1:0] qkValid_q, qkValid_d;
  logic [RS_SIZE-1:0] opL2_q, opL2_d;
  logic [OW-1:0]      opL1_q [RS_SIZE];
  logic [OW-1:0]      opL1_d [RS_SIZE];
  logic [RW-1:0]      robId_q [RS_SIZE];
  logic [RW-1:0]      robId_d [RS_SIZE];
  logic [RW-1:0]      qj_q [RS_SIZE];
  logic [RW-1:0]      qj_d [RS_SIZE];
  logic [RW-1:0]      qk_q [RS_SIZE];
  logic [RW-1:0]      qk_d [RS_SIZE];
  logic [31:0]        vj_q [RS_SIZE];
  logic [31:0]        vj_d [RS_SIZE];
  logic [31:0]        vk_q [RS_SIZE];
  logic [31:0]        vk_d [RS_SIZE];

  logic          aluValid_q, aluValid_d;
  logic [31:0]   aluOpr1_q, aluOpr1_d;
  logic [31:0]   aluOpr2_q, aluOpr2_d;
  logic [RW-1:0] aluRobId_q, aluRobId_d;
  logic [OW-1:0] aluOpL1_q, aluOpL1_d;
  logic          aluOpL2_q, aluOpL2_d;
  logic          full_q, full_d;

  logic [IW-1:0] issueIdx, freeIdx;
  logic          issueFound, freeFound;
  logic [CW-1:0] busyCount;

  // Returns {stillPending, value}; the ALU bus wins when both buses carry the tag.
  function automatic logic [32:0] capture(
    input logic pending, input logic [RW-1:0] tag, input logic [31:0] value,
    input logic aluRdy, input logic [RW-1:0] aluTag, input logic [31:0] aluVal,
    input logic lsbRdy, input logic [RW-1:0] lsbTag, input logic [31:0] lsbVal);
    logic [32:0] result;
    result = {pending, value};
    if (pending && aluRdy && (tag == aluTag))
      result = {1'b0, aluVal};
    else if (pending && lsbRdy && (tag == lsbTag))
      result = {1'b0, lsbVal};
    return result;
  endfunction

  always_comb begin
    busy_d     = busy_q;
    qjValid_d  = qjValid_q;
    qkValid_d  = qkValid_q;
    opL2_d     = opL2_q;
    opL1_d     = opL1_q;
    robId_d    = robId_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    aluValid_d = aluValid_q;
    aluOpr1_d  = aluOpr1_q;
    aluOpr2_d  = aluOpr2_q;
    aluRobId_d = aluRobId_q;
    aluOpL1_d  = aluOpL1_q;
    aluOpL2_d  = aluOpL2_q;
    issueIdx   = '0;
    freeIdx    = '0;
    issueFound = 1'b0;
    freeFound  = 1'b0;
    busyCount  = '0;

    // Both searches look only at start-of-cycle state, so fresh or freed slots wait a cycle.
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (busy_q[i] && !qjValid_q[i] && !qkValid_q[i]) begin
        issueIdx   = IW'(i);
        issueFound = 1'b1;
      end
      if (!busy_q[i]) begin
        freeIdx   = IW'(i);
        freeFound = 1'b1;
      end
    end

    if (need_flush_in) begin
      busy_d     = '0;
      aluValid_d = 1'b0;
    end else begin
      aluValid_d = issueFound;
      if (issueFound) begin
        aluOpr1_d        = vj_q[issueIdx];
        aluOpr2_d        = vk_q[issueIdx];
        aluRobId_d       = robId_q[issueIdx];
        aluOpL1_d        = opL1_q[issueIdx];
        aluOpL2_d        = opL2_q[issueIdx];
        busy_d[issueIdx] = 1'b0;
      end

      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          {qjValid_d[i], vj_d[i]} = capture(qjValid_q[i], qj_q[i], vj_q[i],
            bus.cdb_alu_ready, bus.cdb_alu_rob_id, bus.cdb_alu_value,
            bus.cdb_lsb_ready, bus.cdb_lsb_rob_id, bus.cdb_lsb_value);
          {qkValid_d[i], vk_d[i]} = capture(qkValid_q[i], qk_q[i], vk_q[i],
            bus.cdb_alu_ready, bus.cdb_alu_rob_id, bus.cdb_alu_value,
            bus.cdb_lsb_ready, bus.cdb_lsb_rob_id, bus.cdb_lsb_value);
        end
      end

      if (bus.disp_valid && freeFound) begin
        busy_d[freeIdx]  = 1'b1;
        opL1_d[freeIdx]  = bus.disp_op_L1;
        opL2_d[freeIdx]  = bus.disp_op_L2;
        robId_d[freeIdx] = bus.disp_rob_id;
        qj_d[freeIdx]    = bus.disp_qj;
        qk_d[freeIdx]    = bus.disp_qk;
        {qjValid_d[freeIdx], vj_d[freeIdx]} = capture(bus.disp_qj_valid, bus.disp_qj, bus.disp_vj,
          bus.cdb_alu_ready, bus.cdb_alu_rob_id, bus.cdb_alu_value,
          bus.cdb_lsb_ready, bus.cdb_lsb_rob_id, bus.cdb_lsb_value);
        {qkValid_d[freeIdx], vk_d[freeIdx]} = capture(bus.disp_qk_valid, bus.disp_qk, bus.disp_vk,
          bus.cdb_alu_ready, bus.cdb_alu_rob_id, bus.cdb_alu_value,
          bus.cdb_lsb_ready, bus.cdb_lsb_rob_id, bus.cdb_lsb_value);
      end
    end

    for (int i = 0; i < RS_SIZE; i++)
      busyCount = busyCount + CW'(busy_d[i]);
    full_d = (busyCount == CW'(RS_SIZE));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q     <= '0;
      qjValid_q  <= '0;
      qkValid_q  <= '0;
      opL2_q     <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        opL1_q[i]  <= '0;
        robId_q[i] <= '0;
        qj_q[i]    <= '0;
        qk_q[i]    <= '0;
        vj_q[i]    <= '0;
        vk_q[i]    <= '0;
      end
      aluValid_q <= 1'b0;
      aluOpr1_q  <= '0;
      aluOpr2_q  <= '0;
      aluRobId_q <= '0;
      aluOpL1_q  <= '0;
      aluOpL2_q  <= 1'b0;
      full_q     <= 1'b0;
    end else if (rdy_in) begin
      busy_q     <= busy_d;
      qjValid_q  <= qjValid_d;
      qkValid_q  <= qkValid_d;
      opL2_q     <= opL2_d;
      opL1_q     <= opL1_d;
      robId_q    <= robId_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
      aluValid_q <= aluValid_d;
      aluOpr1_q  <= aluOpr1_d;
      aluOpr2_q  <= aluOpr2_d;
      aluRobId_q <= aluRobId_d;
      aluOpL1_q  <= aluOpL1_d;
      aluOpL2_q  <= aluOpL2_d;
      full_q     <= full_d;
    end
  end

  assign bus.alu_valid  = aluValid_q;
  assign bus.alu_opr1   = aluOpr1_q;
  assign bus.alu_opr2   = aluOpr2_q;
  assign bus.alu_rob_id = aluRobId_q;
  assign bus.alu_op_L1  = aluOpL1_q;
  assign bus.alu_op_L2  = aluOpL2_q;
  assign bus.full       = full_q;
endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: directed scenarios then random traffic, every cycle compared
// against an entry-list model of the reservation station.
module tb_rs_alu;
  localparam int RS = 8;

  typedef struct {
    logic        busy;
    logic [3:0]  opL1;
    logic        opL2;
    logic [3:0]  rob;
    logic [31:0] vj;
    logic [31:0] vk;
    logic        qjv;
    logic [3:0]  qj;
    logic        qkv;
    logic [3:0]  qk;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic flush = 1'b0;

  logic        dValid = 1'b0;
  logic [3:0]  dOpL1 = '0;
  logic        dOpL2 = 1'b0;
  logic [3:0]  dRob = '0;
  logic [31:0] dVj = '0;
  logic [31:0] dVk = '0;
  logic        dQjV = 1'b0;
  logic [3:0]  dQj = '0;
  logic        dQkV = 1'b0;
  logic [3:0]  dQk = '0;
  logic        aRdy = 1'b0;
  logic [3:0]  aTag = '0;
  logic [31:0] aVal = '0;
  logic        lRdy = 1'b0;
  logic [3:0]  lTag = '0;
  logic [31:0] lVal = '0;

  ent_t        m [RS];
  logic        mValid;
  logic [31:0] mOpr1;
  logic [31:0] mOpr2;
  logic [3:0]  mRob;
  logic [3:0]  mOpL1;
  logic        mOpL2;
  logic        mFull;

  int checks = 0;
  int failures = 0;

  rs_alu_if #(.ROB_SIZE_WIDTH(4), .CALC_OP_L1_NUM_WIDTH(4)) bus ();

  assign bus.disp_valid     = dValid;
  assign bus.disp_op_L1     = dOpL1;
  assign bus.disp_op_L2     = dOpL2;
  assign bus.disp_rob_id    = dRob;
  assign bus.disp_vj        = dVj;
  assign bus.disp_vk        = dVk;
  assign bus.disp_qj_valid  = dQjV;
  assign bus.disp_qj        = dQj;
  assign bus.disp_qk_valid  = dQkV;
  assign bus.disp_qk        = dQk;
  assign bus.cdb_alu_ready  = aRdy;
  assign bus.cdb_alu_rob_id = aTag;
  assign bus.cdb_alu_value  = aVal;
  assign bus.cdb_lsb_ready  = lRdy;
  assign bus.cdb_lsb_rob_id = lTag;
  assign bus.cdb_lsb_value  = lVal;

  rs_alu #(.RS_SIZE(RS), .ROB_SIZE_WIDTH(4), .CALC_OP_L1_NUM_WIDTH(4)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .need_flush_in(flush),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // A pending operand snoops the broadcasts; the ALU bus is consulted first.
  function automatic void wake(inout logic pend, input logic [3:0] tag, inout logic [31:0] val);
    if (!pend) return;
    if (aRdy && aTag == tag) begin
      val  = aVal;
      pend = 1'b0;
    end else if (lRdy && lTag == tag) begin
      val  = lVal;
      pend = 1'b0;
    end
  endfunction

  task automatic modelStep();
    ent_t old [RS];
    ent_t e;
    int   pick;
    int   free;
    int   cnt;
    old  = m;
    pick = -1;
    free = -1;
    cnt  = 0;
    if (rst) begin
      for (int i = 0; i < RS; i++) m[i] = '{default: '0};
      mValid = 1'b0; mOpr1 = '0; mOpr2 = '0; mRob = '0; mOpL1 = '0; mOpL2 = 1'b0; mFull = 1'b0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
        mValid = 1'b0;
        mFull  = 1'b0;
      end else begin
        for (int i = 0; i < RS; i++)
          if (pick < 0 && old[i].busy && !old[i].qjv && !old[i].qkv) pick = i;
        for (int i = 0; i < RS; i++)
          if (free < 0 && !old[i].busy) free = i;
        mValid = (pick >= 0);
        if (pick >= 0) begin
          mOpr1 = old[pick].vj; mOpr2 = old[pick].vk; mRob = old[pick].rob;
          mOpL1 = old[pick].opL1; mOpL2 = old[pick].opL2;
          m[pick].busy = 1'b0;
        end
        for (int i = 0; i < RS; i++) begin
          if (old[i].busy) begin
            wake(m[i].qjv, m[i].qj, m[i].vj);
            wake(m[i].qkv, m[i].qk, m[i].vk);
          end
        end
        if (dValid && free >= 0) begin
          e.busy = 1'b1; e.opL1 = dOpL1; e.opL2 = dOpL2; e.rob = dRob;
          e.vj = dVj; e.vk = dVk; e.qjv = dQjV; e.qj = dQj; e.qkv = dQkV; e.qk = dQk;
          wake(e.qjv, e.qj, e.vj);
          wake(e.qkv, e.qk, e.vk);
          m[free] = e;
        end
        for (int i = 0; i < RS; i++) cnt += int'(m[i].busy);
        mFull = (cnt == RS);
      end
    end
  endtask

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkField("alu_valid", 32'(bus.alu_valid), 32'(mValid));
    checkField("alu_opr1", bus.alu_opr1, mOpr1);
    checkField("alu_opr2", bus.alu_opr2, mOpr2);
    checkField("alu_rob_id", 32'(bus.alu_rob_id), 32'(mRob));
    checkField("alu_op_L1", 32'(bus.alu_op_L1), 32'(mOpL1));
    checkField("alu_op_L2", 32'(bus.alu_op_L2), 32'(mOpL2));
    checkField("full", 32'(bus.full), 32'(mFull));
  endtask

  task automatic setDispatch(input logic [3:0] op1, input logic op2, input logic [3:0] rob,
                             input logic [31:0] vj, input logic [31:0] vk,
                             input logic qjv, input logic [3:0] qj,
                             input logic qkv, input logic [3:0] qk);
    dValid = 1'b1; dOpL1 = op1; dOpL2 = op2; dRob = rob; dVj = vj; dVk = vk;
    dQjV = qjv; dQj = qj; dQkV = qkv; dQk = qk;
  endtask

  task automatic setCdbAlu(input logic [3:0] tag, input logic [31:0] val);
    aRdy = 1'b1; aTag = tag; aVal = val;
  endtask

  task automatic setCdbLsb(input logic [3:0] tag, input logic [31:0] val);
    lRdy = 1'b1; lTag = tag; lVal = val;
  endtask

  // One clock: model and DUT see the same inputs, outputs compared 1 time unit after the edge.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
    dValid = 1'b0;
    aRdy   = 1'b0;
    lRdy   = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    logic pendK;
    $display("[TB] start");

    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    checkField("reset_valid", 32'(bus.alu_valid), 32'h0);
    checkField("reset_full", 32'(bus.full), 32'h0);
    checkField("reset_opr1", bus.alu_opr1, 32'h0);
    rst = 1'b0;

    // ADD with both operands ready issues two edges after dispatch.
    setDispatch(4'd0, 1'b0, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus();
    checkField("add_not_yet", 32'(bus.alu_valid), 32'h0);
    applyStimulus();
    checkField("add_valid", 32'(bus.alu_valid), 32'h1);
    checkField("add_opr1", bus.alu_opr1, 32'd5);
    checkField("add_opr2", bus.alu_opr2, 32'd7);
    checkField("add_rob", 32'(bus.alu_rob_id), 32'd3);
    applyStimulus();
    checkField("add_done", 32'(bus.alu_valid), 32'h0);

    // Pending qj woken by the LSB bus.
    setDispatch(4'($urandom), 1'($urandom), 4'd5, $urandom, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0);
    applyStimulus();
    applyStimulus();
    checkField("wait_qj", 32'(bus.alu_valid), 32'h0);
    setCdbLsb(4'd2, 32'h10);
    applyStimulus();
    checkField("wake_edge", 32'(bus.alu_valid), 32'h0);
    applyStimulus();
    checkField("lsb_wake_valid", 32'(bus.alu_valid), 32'h1);
    checkField("lsb_wake_opr1", bus.alu_opr1, 32'h10);
    checkField("lsb_wake_opr2", bus.alu_opr2, 32'h1);

    // Fill every entry waiting on tag 6, then wake them all with one broadcast.
    for (int i = 0; i < RS; i++) begin
      setDispatch(4'($urandom), 1'($urandom), 4'(i + 8), $urandom, $urandom,
                  1'b1, 4'd6, 1'(i % 2), 4'd6);
      applyStimulus();
    end
    checkField("fill_full", 32'(bus.full), 32'h1);
    setDispatch(4'd1, 1'b0, 4'd1, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus();
    checkField("drop_full", 32'(bus.full), 32'h1);
    setCdbAlu(4'd6, 32'd9);
    applyStimulus();
    for (int i = 0; i < RS; i++) begin
      applyStimulus();
      pendK = 1'(i % 2);
      checkField("drain_valid", 32'(bus.alu_valid), 32'h1);
      checkField("drain_order", 32'(bus.alu_rob_id), 32'(i + 8));
      checkField("drain_opr1", bus.alu_opr1, 32'd9);
      if (pendK) checkField("drain_opr2", bus.alu_opr2, 32'd9);
      if (i == 0) checkField("full_drop", 32'(bus.full), 32'h0);
    end
    applyStimulus();

    // Same-cycle bypass from the ALU bus at dispatch.
    setDispatch(4'd2, 1'b0, 4'd7, $urandom, $urandom, 1'b0, 4'd0, 1'b1, 4'd4);
    setCdbAlu(4'd4, 32'hAB);
    applyStimulus();
    applyStimulus();
    checkField("bypass_valid", 32'(bus.alu_valid), 32'h1);
    checkField("bypass_opr2", bus.alu_opr2, 32'hAB);

    // Five entries ready, then a flush discards them.
    for (int i = 0; i < 5; i++) begin
      setDispatch(4'($urandom), 1'($urandom), 4'(i), $urandom, $urandom, 1'b1, 4'd9, 1'b0, 4'd0);
      applyStimulus();
    end
    setCdbLsb(4'd9, $urandom);
    applyStimulus();
    flush = 1'b1;
    applyStimulus();
    checkField("flush_valid", 32'(bus.alu_valid), 32'h0);
    checkField("flush_full", 32'(bus.full), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus();
    setDispatch(4'd3, 1'b1, 4'd2, 32'd11, 32'd12, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus();
    checkField("reuse_entry0", 32'(dut.busy_q), 32'h1);
    applyStimulus();
    checkField("reuse_issue", 32'(bus.alu_rob_id), 32'd2);

    // rdy_in low freezes everything, including an attempted dispatch.
    setDispatch(4'd4, 1'b0, 4'd10, $urandom, $urandom, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus();
    setDispatch(4'd5, 1'b1, 4'd11, $urandom, $urandom, 1'b0, 4'd0, 1'b0, 4'd0);
    applyStimulus();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) setDispatch(4'd6, 1'b0, 4'd12, $urandom, $urandom, 1'b0, 4'd0, 1'b0, 4'd0);
      applyStimulus();
      checkField("freeze_valid", 32'(bus.alu_valid), 32'h1);
      checkField("freeze_rob", 32'(bus.alu_rob_id), 32'd10);
    end
    rdy = 1'b1;
    applyStimulus();
    checkField("resume_rob", 32'(bus.alu_rob_id), 32'd11);
    applyStimulus();
    checkField("ignored_dispatch", 32'(bus.alu_valid), 32'h0);

    // Random traffic over a small tag space so wakeups collide often.
    for (int n = 0; n < 400; n++) begin
      rdy   = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1 && (!mFull || $urandom_range(0, 15) == 0))
        setDispatch(4'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom,
                    1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) setCdbAlu(4'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 1) == 1) setCdbLsb(4'($urandom_range(0, 3)), $urandom);
      applyStimulus();
    end
    rdy = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
